// File: rtl/edge_detect_multi.sv
// Purpose: multi-channel synchronised edge detector with sticky flags and a saturating event counter.
// Latency: pulse/sticky/count update SYNC_STAGES edges after din is first sampled (+FILTER_LEN with DEBOUNCE_EN).
// Backpressure: none; free-running, every accepted edge is reported in the cycle it is detected.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   en, mode         detection enable; 00 rising, 01 falling, 10 both, 11 none
//   din              WIDTH asynchronous channel inputs
//   sticky_clr       per-channel level-sensitive clear of sticky (a same-cycle set wins)
//   cnt_clr          clears edge_count (edges detected in the same cycle are still counted)
//   pulse, any_edge  registered one-cycle edge pulses and their OR
//   sticky           latched per-channel edge flags
//   edge_count       saturating count of channel edges
// Optional macro DEBOUNCE_EN: adds a per-channel stability filter of FILTER_LEN cycles after
// the synchroniser; detection then runs on the filtered value.
module edge_detect_multi #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8,
  parameter int FILTER_LEN  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] din,
  input  logic [WIDTH-1:0] sticky_clr,
  input  logic             cnt_clr,
  output logic [WIDTH-1:0] pulse,
  output logic             any_edge,
  output logic [WIDTH-1:0] sticky,
  output logic [CNT_W-1:0] edge_count
);

  localparam int PC_W   = $clog2(WIDTH + 1);
  // One bit of headroom over the wider of counter and popcount so the clamp sees any overflow.
  localparam int SUM_W  = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
  localparam int WARM_N = SYNC_STAGES + 1;
  localparam int WARM_W = $clog2(WARM_N + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  if (WIDTH < 1 || WIDTH > 32 || SYNC_STAGES < 2 || SYNC_STAGES > 4 ||
      CNT_W < 4 || CNT_W > 16 || FILTER_LEN < 2 || FILTER_LEN > 15) begin : g_param_check
    $error("edge_detect_multi: parameter out of range");
  end

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  sync;
  logic [WIDTH-1:0]                  src;
  logic [WIDTH-1:0]                  prev_q;
  logic [WIDTH-1:0]                  rise;
  logic [WIDTH-1:0]                  fall;
  logic [WIDTH-1:0]                  det;
  logic [WARM_W-1:0]                 warm_q;
  logic                              warm_done;
  logic [PC_W-1:0]                   pc;
  logic [CNT_W-1:0]                  cnt_base;
  logic [SUM_W-1:0]                  sum;

  assign sync      = sync_q[SYNC_STAGES-1];
  assign warm_done = (warm_q == WARM_W'(WARM_N));

  // Synchroniser chain and warm-up counter. The warm-up keeps stale pre-reset levels in the
  // chain from being seen as edges once detection starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      warm_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      if (!warm_done) warm_q <= warm_q + 1'b1;
    end
  end

`ifdef DEBOUNCE_EN
  logic [WIDTH-1:0]      acc_q;
  logic [WIDTH-1:0][3:0] stab_q;

  // A channel's accepted value only moves after sync has disagreed with it for FILTER_LEN
  // consecutive cycles; any agreement restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      stab_q <= '0;
    end else if (!warm_done) begin
      acc_q  <= sync;
      stab_q <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync[i] != acc_q[i]) begin
          if (stab_q[i] == 4'(FILTER_LEN - 1)) begin
            acc_q[i]  <= sync[i];
            stab_q[i] <= '0;
          end else begin
            stab_q[i] <= stab_q[i] + 4'd1;
          end
        end else begin
          stab_q[i] <= '0;
        end
      end
    end
  end

  assign src = acc_q;
`else
  assign src = sync;
`endif

  always_comb begin
    rise = src & ~prev_q;
    fall = ~src & prev_q;
    det  = '0;
    if (en && warm_done) begin
      case (mode)
        2'b00:   det = rise;
        2'b01:   det = fall;
        2'b10:   det = rise | fall;
        default: det = '0;
      endcase
    end
  end

  always_comb begin
    pc = '0;
    for (int i = 0; i < WIDTH; i++) pc = pc + PC_W'(det[i]);
    cnt_base = cnt_clr ? '0 : edge_count;
    sum      = SUM_W'(cnt_base) + SUM_W'(pc);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q     <= '0;
      pulse      <= '0;
      any_edge   <= 1'b0;
      sticky     <= '0;
      edge_count <= '0;
    end else begin
      // During warm-up prev follows sync directly so that, with the filter present, prev and
      // the accepted value leave warm-up agreeing and no spurious edge appears.
      prev_q     <= warm_done ? src : sync;
      pulse      <= det;
      any_edge   <= |det;
      sticky     <= (sticky & ~sticky_clr) | det;
      edge_count <= (sum > SUM_W'(CNT_MAX)) ? CNT_MAX : sum[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_edge_detect_multi.sv
// Purpose: self-checking bench for edge_detect_multi (default build) against a reference model.
// Latency: model predicts every output one edge at a time, sampled 1 time unit after posedge.
// Backpressure: not applicable.
module tb_edge_detect_multi;

  localparam int W = 8;
  localparam int S = 2;
  localparam int C = 8;
  localparam int CMAX = (1 << C) - 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic [W-1:0] din = '1;
  logic [W-1:0] sticky_clr = '0;
  logic         cnt_clr = 1'b0;
  logic [W-1:0] pulse;
  logic         any_edge;
  logic [W-1:0] sticky;
  logic [C-1:0] edge_count;

  int total = 0;
  int bad = 0;

  // Reference model: din as sampled at each clock edge since reset release (index 1 = first edge).
  int           k;
  logic [W-1:0] dh [0:4095];
  logic [W-1:0] m_pulse;
  logic [W-1:0] m_sticky;
  int           m_cnt;

  edge_detect_multi #(.WIDTH(W), .SYNC_STAGES(S), .CNT_W(C), .FILTER_LEN(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .din(din),
    .sticky_clr(sticky_clr), .cnt_clr(cnt_clr), .pulse(pulse), .any_edge(any_edge),
    .sticky(sticky), .edge_count(edge_count)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, expv);
    end
  endtask

  task automatic chk_model();
    chk("pulse", pulse, m_pulse);
    chk("any_edge", any_edge, |m_pulse);
    chk("sticky", sticky, m_sticky);
    chk("edge_count", edge_count, m_cnt);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_pulse"}, pulse, 0);
    chk({tag, "_any"}, any_edge, 0);
    chk({tag, "_sticky"}, sticky, 0);
    chk({tag, "_cnt"}, edge_count, 0);
  endtask

  // One clock: drive inputs, let the edge happen, predict from the detection rules, compare.
  task automatic step(input logic [W-1:0] d, input logic e, input logic [1:0] m,
                      input logic [W-1:0] sc, input logic cc);
    logic [W-1:0] cur, old, det;
    din = d; en = e; mode = m; sticky_clr = sc; cnt_clr = cc;
    @(posedge clk);
    k++;
    dh[k] = d;
    det = '0;
    // The value reaching the detector at edge k was sampled S edges earlier; its predecessor
    // one edge before that. Detection is off for the first S+1 edges after release.
    if (k >= S + 2 && e) begin
      cur = dh[k - S];
      old = dh[k - S - 1];
      case (m)
        2'b00: det = cur & ~old;
        2'b01: det = ~cur & old;
        2'b10: det = cur ^ old;
        default: det = '0;
      endcase
    end
    m_pulse  = det;
    m_sticky = (m_sticky & ~sc) | det;
    m_cnt    = (cc ? 0 : m_cnt) + $countones(det);
    if (m_cnt > CMAX) m_cnt = CMAX;
    #1;
    chk_model();
  endtask

  task automatic do_reset(input logic [W-1:0] d);
    din = d;
    #2 rst_n = 1'b0;
    #1 chk_zero("async_rst");
    @(posedge clk);
    #1 chk_zero("rst_held");
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    m_pulse = '0;
    m_sticky = '0;
    m_cnt = 0;
  endtask

  initial begin
    logic [W-1:0] v;
    logic [W-1:0] rd;
    k = 0; m_pulse = '0; m_sticky = '0; m_cnt = 0;

    // Inputs held high through reset must not produce a rising edge.
    do_reset(8'hFF);
    repeat (10) step(8'hFF, 1'b1, 2'b00, 8'h00, 1'b0);
    chk("warm_sticky", sticky, 0);
    chk("warm_cnt", edge_count, 0);

    // Rising edge on channel 0, then a falling edge that mode 00 ignores.
    repeat (4) step(8'h00, 1'b1, 2'b00, 8'h00, 1'b0);
    repeat (3) step(8'h01, 1'b1, 2'b00, 8'h00, 1'b0);
    chk("rise_pulse", pulse, 8'h01);
    chk("rise_cnt", edge_count, 1);
    step(8'h01, 1'b1, 2'b00, 8'h00, 1'b0);
    chk("rise_one_cycle", pulse, 8'h00);
    repeat (4) step(8'h00, 1'b1, 2'b00, 8'h00, 1'b0);

    // Both edges; sticky clear colliding with a set on channel 0.
    repeat (2) step(8'h00, 1'b1, 2'b10, 8'h00, 1'b0);
    repeat (3) step(8'h03, 1'b1, 2'b10, 8'h00, 1'b0);
    chk("both_pulse03", pulse, 8'h03);
    repeat (2) step(8'h03, 1'b1, 2'b10, 8'h00, 1'b0);
    repeat (2) step(8'h02, 1'b1, 2'b10, 8'h00, 1'b0);
    step(8'h02, 1'b1, 2'b10, 8'h01, 1'b0);
    chk("both_pulse01", pulse, 8'h01);
    chk("set_beats_clr", sticky[0], 1'b1);
    step(8'h02, 1'b1, 2'b10, 8'hFF, 1'b0);
    chk("sticky_cleared", sticky, 0);

    // Level changed while disabled is not reported on re-enable.
    repeat (4) step(8'hFF, 1'b0, 2'b00, 8'h00, 1'b0);
    repeat (4) step(8'hFF, 1'b1, 2'b00, 8'h00, 1'b0);
    chk("reenable_nopulse", sticky, 0);
    repeat (3) step(8'h00, 1'b1, 2'b01, 8'h00, 1'b0);
    chk("fall_pulse", pulse, 8'hFF);
    step(8'h00, 1'b1, 2'b01, 8'h00, 1'b0);

    // Saturation, then a clear in the same cycle as an 8-channel pulse.
    for (int i = 0; i < 40; i++) begin
      v = (i % 2 == 0) ? 8'hFF : 8'h00;
      repeat (2) step(v, 1'b1, 2'b10, 8'h00, 1'b0);
    end
    chk("saturated", edge_count, 8'hFF);
    repeat (2) step(8'hFF, 1'b1, 2'b10, 8'h00, 1'b0);
    step(8'hFF, 1'b1, 2'b10, 8'h00, 1'b1);
    chk("clr_keeps_edges", edge_count, 8);

    // Randomised traffic with a reset in the middle.
    v = 8'hFF;
    for (int i = 0; i < 300; i++) begin
      if (i == 150) begin
        rd = W'($urandom);
        do_reset(rd);
        v = rd;
      end
      if ($urandom_range(0, 2) == 0) v = W'($urandom);
      rd = ($urandom_range(0, 7) == 0) ? W'($urandom) : '0;
      step(v, ($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)), rd,
           ($urandom_range(0, 15) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/edge_detect_multi.md
Name: edge_detect_multi

Overview:
- Parametrised multi-channel edge detector: WIDTH asynchronous inputs pass through synchronisers.
- Each channel can report rising, falling or both edges as a registered one-cycle pulse.
- Per-channel sticky flags and a saturating event counter are kept for slow polling logic.
- Sits at the io_i boundary of a user tile and feeds the controller and status logic.

Parameters:
- WIDTH, 8, number of independent input channels (1..32).
- SYNC_STAGES, 2, synchroniser flops per channel (2..4).
- CNT_W, 8, event counter width (4..16).
- FILTER_LEN, 4, cycles an input must stay stable before it is accepted. Used only with DEBOUNCE_EN (2..15).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  detection enable
- mode  in  2  00 rising, 01 falling, 10 both, 11 none
- din  in  WIDTH  asynchronous channel inputs
- sticky_clr  in  WIDTH  per-bit sticky clear, level-sensitive
- cnt_clr  in  1  event counter clear
- pulse  out  WIDTH  registered one-cycle edge pulses
- any_edge  out  1  registered OR of pulse
- sticky  out  WIDTH  latched edge flags
- edge_count  out  CNT_W  saturating count of channel edges

Behaviour:
- Reset (rst_n low, asynchronous):
  - Synchroniser chain, prev, pulse, any_edge, sticky and edge_count all go to 0.
  - Warm-up counter goes to 0.
- Warm-up:
  - For the first SYNC_STAGES+1 rising clk edges after rst_n deasserts, detection is suppressed.
  - prev still tracks the synchronised value during warm-up.
  - Result: an input held high through reset never produces a false rising edge.
- Pipeline:
  - sync = last synchroniser stage. prev registers sync every cycle, regardless of en and mode.
  - Rising detect = sync & ~prev. Falling detect = ~sync & prev.
  - det = detect selected by mode, masked by en and by warm-up done. mode 11 gives det = 0.
- Latency:
  - Let E0 be the first clk edge that samples a new din value.
  - pulse, any_edge, the sticky set and the counter increment all take effect at edge E0+SYNC_STAGES.
  - pulse is high for exactly one cycle per accepted edge.
- Input glitches: a din pulse shorter than one clk period may be missed. This is permitted.
- Disabled detection: when en=0 or mode=11, prev keeps tracking. Re-enabling therefore produces no pulse for a level that changed while disabled.
- Mode change mid-stream:
  - Takes effect on the det of the same cycle.
  - No pipeline flush.
- sticky[i]:
  - Set when det[i]=1; cleared when sticky_clr[i]=1.
  - Simultaneous set and clear: set wins, so the bit stays 1.
- edge_count:
  - Next value = (cnt_clr ? 0 : edge_count) + popcount(det), saturating at 2^CNT_W-1.
  - Saturation is sticky until cnt_clr. A clear never loses edges detected in the same cycle.
- Width rules:
  - popcount is ceil(log2(WIDTH+1)) bits, zero-extended before the add.
  - The sum is computed one bit wider than CNT_W, then clamped.
- Reset mid-operation: all state clears immediately, and the warm-up restarts on release.

Optional Feature:
- Macro: DEBOUNCE_EN.
- Defined:
  - Each channel inserts a filter after the synchroniser.
  - The filter holds an accepted value and a 4-bit stability counter.
  - When sync differs from the accepted value for FILTER_LEN consecutive cycles, the accepted value updates; any return to the accepted value resets the counter.
  - Detection then operates on the accepted value instead of sync.
  - Latency becomes E0+SYNC_STAGES+FILTER_LEN.
  - During warm-up the accepted value loads sync directly.
  - Bounces shorter than FILTER_LEN cycles produce no pulse.
- Undefined:
  - No filter logic is generated and FILTER_LEN is ignored.
  - Latency is E0+SYNC_STAGES.

Test Plan (WIDTH=8, SYNC_STAGES=2, CNT_W=8, no DEBOUNCE_EN unless stated):
- Reset with din=8'hFF held, release, wait 10 cycles -> pulse=0, sticky=0, edge_count=0 throughout.
- mode=00, en=1, din 00->01 at edge E0 -> pulse=8'h01 after E0+2 for one cycle, any_edge=1, sticky=8'h01, edge_count=1; din 01->00 -> no pulse.
- mode=10, din 00->03, then 03->02 -> pulse=8'h03 then 8'h01; edge_count=3; sticky_clr=8'h01 in the same cycle as a channel-0 pulse -> sticky[0] stays 1.
- en=0, din 00->FF, en=1 -> no pulse; din FF->00 with mode=01 -> pulse=8'hFF, edge_count increases by 8.
- mode=10, toggle din between 00 and FF every 2 cycles for 80 cycles -> edge_count saturates at 8'hFF; cnt_clr asserted together with a pulse of 8'hFF -> edge_count=8.
- DEBOUNCE_EN, FILTER_LEN=4: a 3-cycle high glitch on din[0] -> no pulse; a 6-cycle high on din[0] -> one pulse=8'h01 at E0+6; rst_n dropped mid-count -> all outputs 0 asynchronously.
